alu_rr_scheduler: RTL and testbench

// - Shares one external 8-bit combinational ALU (A, B, 3-bit opcode -> result, zero) among NREQ requesters.
// - Round-robin arbitration; valid/ready handshake on both the request and response sides.
// - Owns the ALU operand/opcode registers and tags each response with the requester ID.
// - Sits between client blocks and the single shared ALU instance.

---
 rtl/alu_rr_scheduler.sv | 169 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external 8-bit combinational ALU among NREQ requesters.
// Optional define ALU_STATS_EN adds saturating stat_ops/stat_zero counters.
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [7:0]        alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_result,
  output logic              rsp_zero
`ifdef ALU_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_zero
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state_r, state_nx_s;
  logic [IDW-1:0] rr_ptr_r, rr_nx_s;
  logic [IDW-1:0] gnt_id_r;
  logic [IDW-1:0] gnt_idx_s, cand_s;
  logic           gnt_found_s;
  int             cand_i_s;
  logic [7:0]     sel_a_s, sel_b_s;
  logic [2:0]     sel_op_s;

  // Grant search: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_i_s    = 0;
    cand_s      = '0;
    sel_a_s     = 8'h00;
    sel_b_s     = 8'h00;
    sel_op_s    = 3'b000;
    for (int k = 0; k < NREQ; k++) begin
      cand_i_s = int'(rr_ptr_r) + k;
      if (cand_i_s >= NREQ) begin
        cand_i_s = cand_i_s - NREQ;
      end else begin
        cand_i_s = cand_i_s;
      end
      cand_s = IDW'(cand_i_s);
      if (!gnt_found_s && req_valid[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == IDW'(i)) begin
        sel_a_s  = req_a[8*i +: 8];
        sel_b_s  = req_b[8*i +: 8];
        sel_op_s = req_op[3*i +: 3];
      end else begin
        sel_a_s  = sel_a_s;
      end
    end
    if (gnt_idx_s == IDW'(NREQ - 1)) begin
      rr_nx_s = '0;
    end else begin
      rr_nx_s = gnt_idx_s + IDW'(1);
    end
  end

  // Next-state logic and the IDLE-only one-hot request accept.
  always_comb begin
    state_nx_s = state_r;
    req_ready  = '0;
    case (state_r)
      IDLE: begin
        if (gnt_found_s) begin
          state_nx_s = EXEC;
          if (!rst) begin
            req_ready[gnt_idx_s] = 1'b1;
          end else begin
            req_ready = '0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: state_nx_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, operand and response registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      gnt_id_r   <= '0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= 3'b000;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 8'h00;
      rsp_zero   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (gnt_found_s) begin
            alu_a      <= sel_a_s;
            alu_b      <= sel_b_s;
            alu_opcode <= sel_op_s;
            gnt_id_r   <= gnt_idx_s;
            rr_ptr_r   <= rr_nx_s;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= gnt_id_r;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  // Saturating operation and zero-result counters, stepped once per EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= 16'h0000;
      stat_zero <= 16'h0000;
    end else if (state_r == EXEC) begin
      if (stat_ops != 16'hFFFF) begin
        stat_ops <= stat_ops + 16'h0001;
      end
      if (alu_zero && (stat_zero != 16'hFFFF)) begin
        stat_zero <= stat_zero + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with a behavioural ALU model.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_opcode;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
`ifdef ALU_STATS_EN
  logic [15:0] stat_ops, stat_zero;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_res [4];
  logic       exp_zero [4];

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_STATS_EN
    , .stat_ops(stat_ops), .stat_zero(stat_zero)
`endif
  );

  // ALU model: add, sub, and, or, xor; other opcodes pass A
  always_comb begin
    case (alu_opcode)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Single request from one requester; leaves the DUT in RESP.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_op[3*id +: 3] = op;
    req_valid = 4'b0001 << id;
    #1;
    check("issue_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << id});
    tick();
    req_valid = 4'b0000;
    check("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b1;
    req_a = 32'd0; req_b = 32'd0; req_op = 12'd0;
    tick(); tick();
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_op", {29'd0, alu_opcode}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    rst = 1'b0;

    // single request: 05 + 03
    issue(0, 8'h05, 8'h03, 3'b000);
    check("single_result", {24'd0, rsp_result}, 32'h08);
    check("single_zero", {31'd0, rsp_zero}, 32'd0);
    check("single_id", {30'd0, rsp_id}, 32'd0);
    check("resp_no_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check("single_done", {31'd0, rsp_valid}, 32'd0);

    // zero and wrap
    issue(0, 8'hFF, 8'h01, 3'b000);
    check("wrap_add_result", {24'd0, rsp_result}, 32'h00);
    check("wrap_add_zero", {31'd0, rsp_zero}, 32'd1);
    tick();
    issue(0, 8'h00, 8'h01, 3'b001);
    check("wrap_sub_result", {24'd0, rsp_result}, 32'hFF);
    check("wrap_sub_zero", {31'd0, rsp_zero}, 32'd0);
    tick();

    // fairness: all four valid from reset
    rst = 1'b1;
    req_a = {8'h0F, 8'hF0, 8'h20, 8'h10};
    req_b = {8'hF0, 8'h10, 8'h02, 8'h01};
    req_op = {3'd3, 3'd0, 3'd1, 3'd0};
    exp_res[0] = 8'h11; exp_zero[0] = 1'b0;
    exp_res[1] = 8'h1E; exp_zero[1] = 1'b0;
    exp_res[2] = 8'h00; exp_zero[2] = 1'b1;
    exp_res[3] = 8'hFF; exp_zero[3] = 1'b0;
    req_valid = 4'b1111;
    tick();
    check("rst_hold_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (g % 4)});
      tick();
      check("rr_exec_ready", {28'd0, req_ready}, 32'd0);
      tick();
      check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rr_rsp_id", {30'd0, rsp_id}, g % 4);
      check("rr_rsp_result", {24'd0, rsp_result}, {24'd0, exp_res[g % 4]});
      check("rr_rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_zero[g % 4]});
      check("rr_resp_ready", {28'd0, req_ready}, 32'd0);
      tick();
      check("rr_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    end

    // backpressure: next grant is requester 1
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", {28'd0, req_ready}, 32'b0010);
    tick(); tick();
    for (int s = 0; s < 5; s++) begin
      tick();
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_id", {30'd0, rsp_id}, 32'd1);
      check("bp_result", {24'd0, rsp_result}, 32'h1E);
      check("bp_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_next_grant", {28'd0, req_ready}, 32'b0100);

    // mid-op reset while requester 2 executes
    tick();
    check("mid_exec_alu_a", {24'd0, alu_a}, 32'hF0);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ptr", {28'd0, req_ready}, 32'b0001);
    req_valid = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

`ifdef ALU_STATS_EN
    check("stat_ops_rst", {16'd0, stat_ops}, 32'd0);
    issue(0, 8'hFF, 8'h01, 3'b000); tick();
    issue(0, 8'h00, 8'h01, 3'b000); tick();
    issue(0, 8'h05, 8'h05, 3'b001); tick();
    check("stat_ops3", {16'd0, stat_ops}, 32'd3);
    check("stat_zero2", {16'd0, stat_zero}, 32'd2);
    force dut.stat_ops = 16'hFFFE;
    #1;
    release dut.stat_ops;
    issue(0, 8'h01, 8'h01, 3'b000); tick();
    check("stat_ops_top", {16'd0, stat_ops}, 32'hFFFF);
    issue(0, 8'h01, 8'h01, 3'b000); tick();
    check("stat_ops_sat", {16'd0, stat_ops}, 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
